sram_dual_port_arbiter: RTL
===========================

Name: sram_dual_port_arbiter

Overview:
- Shares one single-port 1024x32 SRAM macro between two fabric requesters, A and B.
- Each requester has its own valid/ready command channel and its own read-return channel.
- The block arbitrates between A and B, registers the winning command onto the macro pins, and steers read data back to the issuing requester.
- It sits between two fabric-side user ports and the tile's SRAM pin outputs. It keeps the macro disabled until the fabric reports it is configured.

Parameters:
- ADDR_W, 10, SRAM word-address width.
- DATA_W, 32, data width and bit-mask width.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = A always wins a conflict.

Ports:
- UserCLK  in  1  single clock for the whole block, also forwarded to the macro.
- RST  in  1  synchronous, active-high reset.
- CONFIGURED  in  1  fabric configuration done; no grants are issued while low.
- X_VALID  in  1  command request (X = A, B; each X has its own port).
- X_READY  out  1  command accepted this cycle.
- X_WE  in  1  1 = write, 0 = read.
- X_ADDR  in  ADDR_W  word address.
- X_WDATA  in  DATA_W  write data.
- X_BM  in  DATA_W  per-bit write mask; 1 = bit written.
- X_RVALID  out  1  one-cycle pulse marking read data valid.
- X_RDATA  out  DATA_W  read data.
- ADDR_SRAM  out  ADDR_W  macro address (registered).
- DIN_SRAM  out  DATA_W  macro write data (registered).
- BM_SRAM  out  DATA_W  macro bit mask (registered).
- WEN_SRAM  out  1  macro write enable (registered).
- REN_SRAM  out  1  macro read enable (registered).
- MEN_SRAM  out  1  macro enable (registered).
- DOUT_SRAM  in  DATA_W  macro read data.
- CLK_SRAM  out  1  equals UserCLK.
- BUSY  out  1  a read is in flight (stage 1 or 2 occupied).

Behaviour:
- Clock and reset: UserCLK only; RST is synchronous and active-high.
- Reset values:
  - All *_SRAM command outputs 0, including MEN_SRAM = 0.
  - X_READY = 0, X_RVALID = 0, X_RDATA = 0, BUSY = 0.
  - Round-robin pointer = A.
  - FSM = UNCONF.
- FSM, two states:
  - UNCONF: X_READY = 0 and MEN_SRAM = 0. Moves to RUN on a clock edge where CONFIGURED = 1.
  - RUN: arbitration active. Returns to UNCONF on any edge where CONFIGURED = 0.
  - On that return, in-flight reads still complete their return pulses. No new grants are issued.
- Arbitration (combinational, RUN only):
  - Only one requester valid: it is granted.
  - Both valid, FIXED_PRIO = 1: A is granted.
  - Both valid, FIXED_PRIO = 0: the side the pointer names is granted. After each contested grant the pointer moves to the other side; uncontested grants leave it unchanged.
  - X_READY = grant_X. X_READY may depend combinationally on X_VALID.
  - A command transfers when X_VALID & X_READY. Requesters hold the command stable until ready.
- Stage 0, command register (edge E0, the edge ending the accept cycle):
  - On a transfer, the *_SRAM outputs load ADDR/WDATA/BM from the winner.
  - WEN_SRAM = WE; REN_SRAM = ~WE; MEN_SRAM = 1.
  - With no transfer: MEN_SRAM = 0, WEN_SRAM = 0, REN_SRAM = 0; ADDR/DIN/BM hold their last value.
- Stage 1: the macro samples its pins at edge E1. A pipeline tag {is_read, owner} travels with each command.
- Stage 2: at edge E2, if the tag shows a read, DOUT_SRAM is captured into owner's X_RDATA and owner's X_RVALID is pulsed for exactly one cycle.
  - X_RDATA holds its value until the next capture for that requester.
- Latency and throughput:
  - Read latency: X_RVALID is high in the cycle two edges after the accept cycle.
  - One command per cycle sustained; back-to-back reads return in issue order.
  - Writes produce no response.
- Read-after-write to the same address in consecutive cycles returns the new data; the macro is write-before-read across cycles, so no bypass is needed.
- Reset mid-operation: RST clears the pipeline tags, so pending return pulses are dropped.
- BUSY = stage-1 or stage-2 tag is a read.

Test Plan:
- Reset / config gating: hold RST 2 cycles, CONFIGURED = 0, A_VALID = 1 → A_READY = 0 and MEN_SRAM = 0 throughout. Raise CONFIGURED → A_READY = 1 one cycle later.
- Write then read, port A: write addr 0x005, data 0xDEADBEEF, BM = all ones; next cycle read 0x005 → A_RVALID pulses 2 cycles after the read accept with A_RDATA = 0xDEADBEEF; B_RVALID stays 0.
- Bit mask: write 0xFFFFFFFF to 0x010, then write 0x00000000 with BM = 0x0000FFFF, then read 0x010 → 0xFFFF0000.
- Round-robin contention: A and B both hold VALID for 4 cycles, FIXED_PRIO = 0 → grants A, B, A, B. With FIXED_PRIO = 1 → grants A, A, A, A and B_READY = 0.
- Interleaved reads: A reads 0x001, then B reads 0x002 the next cycle, memory preloaded with 0x11 / 0x22 → A_RVALID with 0x11, then B_RVALID with 0x22 the following cycle.
- CONFIGURED drop with a read in flight: the pending read still returns; no new READY until CONFIGURED is 1 again. RST asserted with a read in flight → no RVALID pulse.

Source files
------------

// File: rtl/sram_dual_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_dual_port_arbiter
//
// Shares one single-port SRAM macro between two fabric requesters (A and B).
// Each requester has a valid/ready command channel and a read-return channel.
// The winning command is registered onto the macro pins; a {is_read, owner}
// tag follows it down the pipeline so read data is steered back to the
// requester that issued it. The macro stays disabled until CONFIGURED.
//
// Ports:
//   UserCLK            block clock, forwarded to the macro as CLK_SRAM
//   RST                synchronous, active-high reset
//   CONFIGURED         fabric configuration done; no grants while low
//   A_* / B_*          per-requester command (VALID/READY/WE/ADDR/WDATA/BM)
//                      and read return (RVALID pulse, RDATA held)
//   *_SRAM outputs     registered macro command pins (ADDR/DIN/BM/WEN/REN/MEN)
//   DOUT_SRAM          macro read data, valid the cycle after the macro edge
//   BUSY               a read occupies pipeline stage 1 or 2
// ----------------------------------------------------------------------------
module sram_dual_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic              UserCLK,
   input  logic              RST,
   input  logic              CONFIGURED,
   // requester A
   input  logic              A_VALID,
   output logic              A_READY,
   input  logic              A_WE,
   input  logic [ADDR_W-1:0] A_ADDR,
   input  logic [DATA_W-1:0] A_WDATA,
   input  logic [DATA_W-1:0] A_BM,
   output logic              A_RVALID,
   output logic [DATA_W-1:0] A_RDATA,
   // requester B
   input  logic              B_VALID,
   output logic              B_READY,
   input  logic              B_WE,
   input  logic [ADDR_W-1:0] B_ADDR,
   input  logic [DATA_W-1:0] B_WDATA,
   input  logic [DATA_W-1:0] B_BM,
   output logic              B_RVALID,
   output logic [DATA_W-1:0] B_RDATA,
   // SRAM macro pins
   output logic [ADDR_W-1:0] ADDR_SRAM,
   output logic [DATA_W-1:0] DIN_SRAM,
   output logic [DATA_W-1:0] BM_SRAM,
   output logic              WEN_SRAM,
   output logic              REN_SRAM,
   output logic              MEN_SRAM,
   input  logic [DATA_W-1:0] DOUT_SRAM,
   output logic              CLK_SRAM,
   output logic              BUSY
);

   localparam logic [0:0] ST_UNCONF = 1'b0;
   localparam logic [0:0] ST_RUN    = 1'b1;

   localparam logic P_FIXED = (FIXED_PRIO != 0);

   // state
   logic [0:0]        r_state;
   logic              r_rr_ptr;      // 0 = A wins next conflict, 1 = B

   // stage 0: macro command registers
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic [DATA_W-1:0] r_bm;
   logic              r_wen;
   logic              r_ren;
   logic              r_men;

   // pipeline tags: stage 1 = command on macro pins, stage 2 = data on DOUT
   logic              r_s1_rd;
   logic              r_s1_own;      // 0 = A, 1 = B
   logic              r_s2_rd;
   logic              r_s2_own;

   // read return
   logic              r_a_rvalid;
   logic              r_b_rvalid;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;

   // arbitration
   logic              w_run;
   logic              w_gnt_a;
   logic              w_gnt_b;
   logic              w_xfer;
   logic              w_contested;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_bm;

   // Grants also require CONFIGURED in the current cycle, so a drop of
   // CONFIGURED blocks new commands immediately rather than one edge late.
   always_comb begin
      w_run   = (r_state == ST_RUN) && CONFIGURED;
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (w_run) begin
         if (A_VALID && B_VALID) begin
            if (P_FIXED || (r_rr_ptr == 1'b0)) begin
               w_gnt_a = 1'b1;
            end else begin
               w_gnt_b = 1'b1;
            end
         end else begin
            w_gnt_a = A_VALID;
            w_gnt_b = B_VALID;
         end
      end
   end

   always_comb begin
      w_xfer      = w_gnt_a | w_gnt_b;
      w_contested = A_VALID & B_VALID & w_xfer;
      if (w_gnt_b) begin
         w_we    = B_WE;
         w_addr  = B_ADDR;
         w_wdata = B_WDATA;
         w_bm    = B_BM;
      end else begin
         w_we    = A_WE;
         w_addr  = A_ADDR;
         w_wdata = A_WDATA;
         w_bm    = A_BM;
      end
   end

   always_ff @(posedge UserCLK) begin
      if (RST) begin
         r_state    <= ST_UNCONF;
         r_rr_ptr   <= 1'b0;
         r_addr     <= '0;
         r_din      <= '0;
         r_bm       <= '0;
         r_wen      <= 1'b0;
         r_ren      <= 1'b0;
         r_men      <= 1'b0;
         r_s1_rd    <= 1'b0;
         r_s1_own   <= 1'b0;
         r_s2_rd    <= 1'b0;
         r_s2_own   <= 1'b0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         case (r_state)
            ST_UNCONF: if (CONFIGURED)  r_state <= ST_RUN;
            default:   if (!CONFIGURED) r_state <= ST_UNCONF;
         endcase

         if (w_contested && !P_FIXED) begin
            r_rr_ptr <= ~r_rr_ptr;
         end

         // stage 0: address/data/mask hold when idle; only enables drop
         if (w_xfer) begin
            r_addr <= w_addr;
            r_din  <= w_wdata;
            r_bm   <= w_bm;
            r_wen  <= w_we;
            r_ren  <= ~w_we;
            r_men  <= 1'b1;
         end else begin
            r_wen  <= 1'b0;
            r_ren  <= 1'b0;
            r_men  <= 1'b0;
         end

         // tags keep moving after CONFIGURED drops so in-flight reads finish
         r_s1_rd  <= w_xfer & ~w_we;
         r_s1_own <= w_gnt_b;
         r_s2_rd  <= r_s1_rd;
         r_s2_own <= r_s1_own;

         r_a_rvalid <= r_s2_rd & ~r_s2_own;
         r_b_rvalid <= r_s2_rd &  r_s2_own;
         if (r_s2_rd && !r_s2_own) r_a_rdata <= DOUT_SRAM;
         if (r_s2_rd &&  r_s2_own) r_b_rdata <= DOUT_SRAM;
      end
   end

   assign A_READY   = w_gnt_a;
   assign B_READY   = w_gnt_b;
   assign A_RVALID  = r_a_rvalid;
   assign B_RVALID  = r_b_rvalid;
   assign A_RDATA   = r_a_rdata;
   assign B_RDATA   = r_b_rdata;
   assign ADDR_SRAM = r_addr;
   assign DIN_SRAM  = r_din;
   assign BM_SRAM   = r_bm;
   assign WEN_SRAM  = r_wen;
   assign REN_SRAM  = r_ren;
   assign MEN_SRAM  = r_men;
   assign CLK_SRAM  = UserCLK;
   assign BUSY      = r_s1_rd | r_s2_rd;

endmodule
